// File: rtl/fpmv_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fpmv_arbiter_pkg
// Shared definitions for the FP move/sign-inject/classify arbiter slice:
//   - FN_* op encodings understood by the shared unit
//   - requester-ID width helper derived from NUM_REQ
//   - performance counter width (used when FPMV_ARB_PERF_EN is defined)
// -----------------------------------------------------------------------------
package fpmv_arbiter_pkg;

  // Op encodings carried on the 3-bit op field of every requester.
  typedef enum logic [2:0] {
    FN_FSGNJ   = 3'd0,
    FN_FSGNJN  = 3'd1,
    FN_FSGNJX  = 3'd2,
    FN_FMV_X_W = 3'd3,
    FN_FMV_W_X = 3'd4,
    FN_FCLASS  = 3'd5
  } fpmv_fn_e;

  localparam int unsigned OP_W       = 3;
  localparam int unsigned FFLAGS_W   = 5;
  localparam int unsigned PERF_CNT_W = 32;

  // Width of a requester ID; never below one bit so a 1-requester build still
  // has a legal vector.
  function automatic int unsigned reqIdWidth(input int unsigned numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

endpackage

// File: rtl/fpmv_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// fpmv_arb_id_fifo
// Synchronous FIFO holding the requester ID of every operation in flight in the
// shared unit, in issue order. The head entry names the owner of the next
// returning result.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears pointers/count)
//   push_i     write data_i at the tail (ignored while full)
//   data_i     requester ID to record
//   pop_i      drop the head entry (ignored while empty)
//   data_o     head entry
//   full_o     count == DEPTH
//   empty_o    count == 0
//   count_o    occupancy, clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module fpmv_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wrPtr_d = wrPtr_q + PTR_W'(doPush);
    rdPtr_d = rdPtr_q + PTR_W'(doPop);
    count_d = count_q + (PTR_W+1)'(doPush) - (PTR_W+1)'(doPop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fpmv_arbiter.sv
// -----------------------------------------------------------------------------
// fpmv_arbiter
// Shares one 2-stage, in-order FP move/sign-inject/classify unit between
// NUM_REQ requesters. Issue is granted round-robin in the same cycle, the
// granted ID is queued, and each returning result is routed to the ID at the
// queue head. Results and fflags are passed through unregistered.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid_i / req_ready_o    per-requester issue handshake
//   req_op_i / req_a_i / req_b_i packed per-requester op and operands
//   fu_valid_o / fu_ready_i      issue handshake to the unit
//   fu_op_o / fu_a_o / fu_b_o    granted op and operands
//   fu_valid_i / fu_ready_o      result handshake from the unit
//   fu_result_i / fu_fflags_i    unit result and flags
//   rsp_valid_o / rsp_ready_i    per-requester response handshake
//   rsp_result_o / rsp_fflags_o  shared response buses
//   err_orphan_o                 sticky: result arrived with no owner queued
//   perf_issue_o, perf_stall_o   only when FPMV_ARB_PERF_EN is defined
// While rst is high every output is driven to zero.
// -----------------------------------------------------------------------------
module fpmv_arbiter
  import fpmv_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned EXPWIDTH  = 8,
  parameter int unsigned PRECISION = 24,
  parameter int unsigned ID_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [OP_W*NUM_REQ-1:0]         req_op_i,
  input  logic [(EXPWIDTH+PRECISION)*NUM_REQ-1:0] req_a_i,
  input  logic [(EXPWIDTH+PRECISION)*NUM_REQ-1:0] req_b_i,
  output logic                            fu_valid_o,
  input  logic                            fu_ready_i,
  output logic [OP_W-1:0]                 fu_op_o,
  output logic [EXPWIDTH+PRECISION-1:0]   fu_a_o,
  output logic [EXPWIDTH+PRECISION-1:0]   fu_b_o,
  input  logic                            fu_valid_i,
  output logic                            fu_ready_o,
  input  logic [EXPWIDTH+PRECISION-1:0]   fu_result_i,
  input  logic [FFLAGS_W-1:0]             fu_fflags_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  input  logic [NUM_REQ-1:0]              rsp_ready_i,
  output logic [EXPWIDTH+PRECISION-1:0]   rsp_result_o,
  output logic [FFLAGS_W-1:0]             rsp_fflags_o,
  output logic                            err_orphan_o
`ifdef FPMV_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W*NUM_REQ-1:0]   perf_issue_o,
  output logic [PERF_CNT_W-1:0]           perf_stall_o
`endif
);

  localparam int unsigned W    = EXPWIDTH + PRECISION;
  localparam int unsigned ID_W = reqIdWidth(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(ID_DEPTH) + 1;

  logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
  logic             errOrphan_q, errOrphan_d;
  logic [ID_W-1:0]  grant;
  logic [ID_W:0]    searchIdx;
  logic [ID_W:0]    nextIdx;
  logic             found;
  logic             anyValid;
  logic             issue;
  logic             pop;
  logic [ID_W-1:0]  headId;
  logic             fifoFull, fifoEmpty;
  logic [CNT_W-1:0] fifoCount;

  assign anyValid = |req_valid_i;

  // Round-robin search: first valid requester at or above rrPtr_q, wrapping.
  always_comb begin
    grant     = '0;
    searchIdx = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      searchIdx = (ID_W+1)'(rrPtr_q) + (ID_W+1)'(i);
      if (searchIdx >= (ID_W+1)'(NUM_REQ)) begin
        searchIdx = searchIdx - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid_i[searchIdx[ID_W-1:0]]) begin
        found = 1'b1;
        grant = searchIdx[ID_W-1:0];
      end
    end
  end

  // A full queue blocks issue even if the head pops this cycle, so issue never
  // depends combinationally on the response side.
  assign fu_valid_o = !rst && anyValid && !fifoFull;
  assign issue      = fu_valid_o && fu_ready_i;

  assign fu_op_o = rst ? '0 : req_op_i[grant*OP_W +: OP_W];
  assign fu_a_o  = rst ? '0 : req_a_i[grant*W +: W];
  assign fu_b_o  = rst ? '0 : req_b_i[grant*W +: W];

  always_comb begin
    req_ready_o = '0;
    if (issue) begin
      req_ready_o[grant] = 1'b1;
    end
  end

  // Results with no queued owner are drained so the unit never wedges.
  assign fu_ready_o = !rst && (fifoEmpty || rsp_ready_i[headId]);
  assign pop        = fu_valid_i && fu_ready_o && !fifoEmpty;

  always_comb begin
    rsp_valid_o = '0;
    if (!rst && fu_valid_i && !fifoEmpty) begin
      rsp_valid_o[headId] = 1'b1;
    end
  end

  assign rsp_result_o = rst ? '0 : fu_result_i;
  assign rsp_fflags_o = rst ? '0 : fu_fflags_i;
  assign err_orphan_o = !rst && errOrphan_q;

  // Pointer moves past the granted requester; wrap at NUM_REQ, which need not
  // be a power of two.
  always_comb begin
    nextIdx     = (ID_W+1)'(grant) + (ID_W+1)'(1);
    rrPtr_d     = rrPtr_q;
    errOrphan_d = errOrphan_q || (fu_valid_i && fifoEmpty);
    if (issue) begin
      rrPtr_d = (nextIdx == (ID_W+1)'(NUM_REQ)) ? '0 : nextIdx[ID_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q     <= '0;
      errOrphan_q <= 1'b0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      errOrphan_q <= errOrphan_d;
    end
  end

  fpmv_arb_id_fifo #(
    .DEPTH (ID_DEPTH),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (issue),
    .data_i  (grant),
    .pop_i   (pop),
    .data_o  (headId),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  fifoCountConsistent: assert property (@(posedge clk) disable iff (rst)
    fifoEmpty == (fifoCount == '0));

`ifdef FPMV_ARB_PERF_EN
  // Per-requester issue counters and a shared stall counter. The two stall
  // conditions are disjoint: a full queue already drops fu_valid_o.
  logic [PERF_CNT_W-1:0] perfIssue_q [NUM_REQ];
  logic [PERF_CNT_W-1:0] perfStall_q;
  logic                  stallCycle;

  assign stallCycle = (fu_valid_o && !fu_ready_i) || (!rst && anyValid && fifoFull);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        perfIssue_q[k] <= '0;
      end
      perfStall_q <= '0;
    end else begin
      if (issue) begin
        perfIssue_q[grant] <= perfIssue_q[grant] + PERF_CNT_W'(1);
      end
      if (stallCycle) begin
        perfStall_q <= perfStall_q + PERF_CNT_W'(1);
      end
    end
  end

  always_comb begin
    perf_issue_o = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      perf_issue_o[k*PERF_CNT_W +: PERF_CNT_W] = rst ? '0 : perfIssue_q[k];
    end
  end

  assign perf_stall_o = rst ? '0 : perfStall_q;
`else
  // Counters are not built; behaviour is otherwise identical.
`endif

endmodule

// File: tb/tb_fpmv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpmv_arbiter
// Directed, table-driven bench for fpmv_arbiter with 4 requesters and 32-bit
// operands. Each vector is one cycle: inputs driven after the falling edge,
// outputs compared shortly afterwards, state advancing at the rising edge.
// The shared unit is played by the vectors themselves (results returned two
// cycles after issue where a scenario needs it).
// -----------------------------------------------------------------------------
module tb_fpmv_arbiter;
  import fpmv_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid_i;
  logic [NR-1:0]   req_ready_o;
  logic [3*NR-1:0] req_op_i;
  logic [W*NR-1:0] req_a_i;
  logic [W*NR-1:0] req_b_i;
  logic            fu_valid_o;
  logic            fu_ready_i;
  logic [2:0]      fu_op_o;
  logic [W-1:0]    fu_a_o;
  logic [W-1:0]    fu_b_o;
  logic            fu_valid_i;
  logic            fu_ready_o;
  logic [W-1:0]    fu_result_i;
  logic [4:0]      fu_fflags_i;
  logic [NR-1:0]   rsp_valid_o;
  logic [NR-1:0]   rsp_ready_i;
  logic [W-1:0]    rsp_result_o;
  logic [4:0]      rsp_fflags_o;
  logic            err_orphan_o;
`ifdef FPMV_ARB_PERF_EN
  logic [32*NR-1:0] perf_issue_o;
  logic [31:0]      perf_stall_o;
`endif

  always #5 clk = ~clk;

  fpmv_arbiter #(
    .NUM_REQ   (NR),
    .EXPWIDTH  (8),
    .PRECISION (24),
    .ID_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .fu_valid_o   (fu_valid_o),
    .fu_ready_i   (fu_ready_i),
    .fu_op_o      (fu_op_o),
    .fu_a_o       (fu_a_o),
    .fu_b_o       (fu_b_o),
    .fu_valid_i   (fu_valid_i),
    .fu_ready_o   (fu_ready_o),
    .fu_result_i  (fu_result_i),
    .fu_fflags_i  (fu_fflags_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_fflags_o (rsp_fflags_o),
    .err_orphan_o (err_orphan_o)
`ifdef FPMV_ARB_PERF_EN
    ,
    .perf_issue_o (perf_issue_o),
    .perf_stall_o (perf_stall_o)
`endif
  );

  typedef struct {
    logic          rst;
    logic [NR-1:0] reqValid;
    logic          fuReady;
    logic          fuValidIn;
    logic [NR-1:0] rspReady;
    logic [NR-1:0] expReqReady;
    logic          expFuValid;
    int            expGrant;
    logic [NR-1:0] expRspValid;
    logic          expFuReady;
    logic          expErr;
  } vec_t;

  int   errorCount = 0;
  int   checkCount = 0;
  int   seed       = 0;
  vec_t table_q [16];

  function automatic vec_t mkVec(input logic r, input logic [NR-1:0] v, input logic fr,
                                 input logic fv, input logic [NR-1:0] rr,
                                 input logic [NR-1:0] eRdy, input logic eFv, input int eG,
                                 input logic [NR-1:0] eRsp, input logic eFr, input logic eErr);
    vec_t t;
    t.rst = r; t.reqValid = v; t.fuReady = fr; t.fuValidIn = fv; t.rspReady = rr;
    t.expReqReady = eRdy; t.expFuValid = eFv; t.expGrant = eG;
    t.expRspValid = eRsp; t.expFuReady = eFr; t.expErr = eErr;
    return t;
  endfunction

  // Compares one value and reports a failure on its own line.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs after the falling edge and checks the outputs.
  task automatic applyStimulus(input vec_t t, input string tag);
    logic [W-1:0] expResult;
    logic [4:0]   expFlags;
    @(negedge clk);
    seed++;
    rst         = t.rst;
    req_valid_i = t.reqValid;
    fu_ready_i  = t.fuReady;
    fu_valid_i  = t.fuValidIn;
    rsp_ready_i = t.rspReady;
    fu_result_i = 32'hC500_0000 | 32'(seed);
    fu_fflags_i = 5'(seed);
    expResult   = t.rst ? 32'h0 : fu_result_i;
    expFlags    = t.rst ? 5'h0 : fu_fflags_i;
    #1;
    checkOutput({tag, " reqReady"}, 32'(req_ready_o), 32'(t.expReqReady));
    checkOutput({tag, " fuValid"},  32'(fu_valid_o),  32'(t.expFuValid));
    checkOutput({tag, " rspValid"}, 32'(rsp_valid_o), 32'(t.expRspValid));
    checkOutput({tag, " fuReady"},  32'(fu_ready_o),  32'(t.expFuReady));
    checkOutput({tag, " errOrphan"}, 32'(err_orphan_o), 32'(t.expErr));
    checkOutput({tag, " rspResult"}, rsp_result_o, expResult);
    checkOutput({tag, " rspFflags"}, 32'(rsp_fflags_o), 32'(expFlags));
    if (t.expFuValid) begin
      checkOutput({tag, " fuOp"}, 32'(fu_op_o), 32'(3'(FN_FSGNJ) + 3'(t.expGrant)));
      checkOutput({tag, " fuA"},  fu_a_o, 32'h3F80_0000 + 32'(t.expGrant));
      checkOutput({tag, " fuB"},  fu_b_o, 32'hBF80_0000 + 32'(t.expGrant));
    end
    if (t.rst) begin
      checkOutput({tag, " fuOpZero"}, 32'(fu_op_o), 32'h0);
      checkOutput({tag, " fuAZero"},  fu_a_o, 32'h0);
      checkOutput({tag, " fuBZero"},  fu_b_o, 32'h0);
`ifdef FPMV_ARB_PERF_EN
      checkOutput({tag, " perfIssueZero"}, 32'(perf_issue_o != '0), 32'h0);
      checkOutput({tag, " perfStallZero"}, perf_stall_o, 32'h0);
`endif
    end
  endtask

  initial begin
    // Requester k: op FN_FSGNJ+k, a = 0x3F800000+k, b = 0xBF800000+k.
    for (int k = 0; k < NR; k++) begin
      req_op_i[3*k +: 3] = 3'(FN_FSGNJ) + 3'(k);
      req_a_i[W*k +: W]  = 32'h3F80_0000 + 32'(k);
      req_b_i[W*k +: W]  = 32'hBF80_0000 + 32'(k);
    end
    rst         = 1'b1;
    req_valid_i = '0;
    fu_ready_i  = 1'b0;
    fu_valid_i  = 1'b0;
    rsp_ready_i = '0;
    fu_result_i = '0;
    fu_fflags_i = '0;
    repeat (2) @(posedge clk);

    applyStimulus(mkVec(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0), "reset");

    // Round-robin streaming, in-order routing, rr_ptr=2 search, backpressure.
    //                   rst valid   frdy fv  rspRdy   expRdy  eFv g  expRsp  eFr err
    table_q[0]  = mkVec(0, 4'b1111, 1, 0, 4'b1111, 4'b0001, 1, 0, 4'b0000, 1, 0);
    table_q[1]  = mkVec(0, 4'b1111, 1, 0, 4'b1111, 4'b0010, 1, 1, 4'b0000, 1, 0);
    table_q[2]  = mkVec(0, 4'b1111, 1, 1, 4'b1111, 4'b0100, 1, 2, 4'b0001, 1, 0);
    table_q[3]  = mkVec(0, 4'b1111, 1, 1, 4'b1111, 4'b1000, 1, 3, 4'b0010, 1, 0);
    table_q[4]  = mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b0100, 1, 0);
    table_q[5]  = mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b1000, 1, 0);
    table_q[6]  = mkVec(0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1, 0);
    table_q[7]  = mkVec(0, 4'b0010, 1, 0, 4'b1111, 4'b0010, 1, 1, 4'b0000, 1, 0);
    table_q[8]  = mkVec(0, 4'b1010, 1, 0, 4'b1111, 4'b1000, 1, 3, 4'b0000, 1, 0);
    table_q[9]  = mkVec(0, 4'b1010, 1, 1, 4'b1111, 4'b0010, 1, 1, 4'b0010, 1, 0);
    table_q[10] = mkVec(0, 4'b0000, 1, 1, 4'b0111, 4'b0000, 0, 0, 4'b1000, 0, 0);
    table_q[11] = mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b1000, 1, 0);
    table_q[12] = mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b0010, 1, 0);
    table_q[13] = mkVec(0, 4'b0001, 0, 0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 1, 0);
    table_q[14] = mkVec(0, 4'b0001, 1, 0, 4'b1111, 4'b0001, 1, 0, 4'b0000, 1, 0);
    table_q[15] = mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b0001, 1, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(table_q[i], $sformatf("vec%0d", i));
    end

    // Fill to ID_DEPTH with responses held off; full blocks issue even while
    // the head pops; then drain in order (rr_ptr starts at 1).
    applyStimulus(mkVec(0, 4'b1111, 1, 0, 4'b0000, 4'b0010, 1, 1, 4'b0000, 1, 0), "full0");
    applyStimulus(mkVec(0, 4'b1111, 1, 0, 4'b0000, 4'b0100, 1, 2, 4'b0000, 0, 0), "full1");
    applyStimulus(mkVec(0, 4'b1111, 1, 0, 4'b0000, 4'b1000, 1, 3, 4'b0000, 0, 0), "full2");
    applyStimulus(mkVec(0, 4'b1111, 1, 0, 4'b0000, 4'b0001, 1, 0, 4'b0000, 0, 0), "full3");
    applyStimulus(mkVec(0, 4'b1111, 1, 1, 4'b0000, 4'b0000, 0, 0, 4'b0010, 0, 0), "full4");
    applyStimulus(mkVec(0, 4'b1111, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b0010, 1, 0), "full5");
    applyStimulus(mkVec(0, 4'b1111, 1, 1, 4'b1111, 4'b0010, 1, 1, 4'b0100, 1, 0), "full6");
    applyStimulus(mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b1000, 1, 0), "full7");
    applyStimulus(mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b0001, 1, 0), "full8");
    applyStimulus(mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b0010, 1, 0), "full9");
    applyStimulus(mkVec(0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1, 0), "full10");

    // Orphan result with an empty queue: drained, not routed, flag sticks.
    applyStimulus(mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1, 0), "orph0");
    applyStimulus(mkVec(0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1, 1), "orph1");
    applyStimulus(mkVec(0, 4'b0100, 1, 0, 4'b1111, 4'b0100, 1, 2, 4'b0000, 1, 1), "orph2");
    applyStimulus(mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b0100, 1, 1), "orph3");
    applyStimulus(mkVec(0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1, 1), "orph4");

    // Reset with three entries queued (rr_ptr=3): outputs forced low, queue
    // and rr_ptr cleared, orphan flag cleared.
    applyStimulus(mkVec(0, 4'b1111, 1, 0, 4'b0000, 4'b1000, 1, 3, 4'b0000, 1, 1), "rst0");
    applyStimulus(mkVec(0, 4'b1111, 1, 0, 4'b0000, 4'b0001, 1, 0, 4'b0000, 0, 1), "rst1");
    applyStimulus(mkVec(0, 4'b1111, 1, 0, 4'b0000, 4'b0010, 1, 1, 4'b0000, 0, 1), "rst2");
    applyStimulus(mkVec(1, 4'b1111, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 0), "rst3");
    applyStimulus(mkVec(0, 4'b1010, 1, 0, 4'b1111, 4'b0010, 1, 1, 4'b0000, 1, 0), "rst4");
    applyStimulus(mkVec(0, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 4'b0010, 1, 0), "rst5");
    applyStimulus(mkVec(0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1, 0), "rst6");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fpmv_arbiter.md
Name: fpmv_arbiter

Overview:
- Shares one pipelined FP move/sign-inject/classify unit (2-stage, valid/ready, in-order) between NUM_REQ requesters, e.g. per-lane-group issue ports of the FPU.
- Grants issue round-robin, records the granted requester ID in an in-order ID FIFO, and routes each returning result to the owning requester.
- Sits between the FPU issue logic and the unit; no datapath arithmetic of its own.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
EXPWIDTH, 8, exponent width of operands
PRECISION, 24, significand width incl. hidden bit; operand width W = EXPWIDTH+PRECISION
ID_DEPTH, 4, ID FIFO entries (power of 2, >= unit latency 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
req_op_i  in  3*NUM_REQ  packed op fields, requester k at [3k+2:3k]
req_a_i  in  W*NUM_REQ  packed operand a
req_b_i  in  W*NUM_REQ  packed operand b
fu_valid_o  out  1  issue valid to unit
fu_ready_i  in  1  unit in_ready
fu_op_o  out  3  granted op
fu_a_o  out  W  granted a
fu_b_o  out  W  granted b
fu_valid_i  in  1  unit out_valid
fu_ready_o  out  1  unit out_ready
fu_result_i  in  W  unit result
fu_fflags_i  in  5  unit fflags
rsp_valid_o  out  NUM_REQ  per-requester response valid (one-hot or zero)
rsp_ready_i  in  NUM_REQ  per-requester response ready
rsp_result_o  out  W  shared result bus
rsp_fflags_o  out  5  shared fflags bus
err_orphan_o  out  1  sticky: unit produced result with ID FIFO empty

Behaviour:
- Reset:
  - rr_ptr=0, FIFO rd/wr ptr=0, count=0, err_orphan_o=0.
  - While rst=1 all outputs forced 0.
- Arbitration is combinational, 0-cycle.
  - Grant g = first requester with req_valid_i set, searching from rr_ptr upward with wrap.
  - can_issue = any valid && fu_ready_i && count<ID_DEPTH.
  - fu_valid_o = any valid && count<ID_DEPTH.
  - fu_op/a/b_o = fields of g.
  - req_ready_o[g] = can_issue; all other bits 0.
- Issue handshake = fu_valid_o && fu_ready_i. On issue:
  - push g into FIFO.
  - rr_ptr <= (g+1) mod NUM_REQ; rr_ptr holds otherwise.
- Response routing, FIFO head h:
  - rsp_valid_o[h] = fu_valid_i && count>0.
  - fu_ready_o = count>0 ? rsp_ready_i[h] : 1.
  - rsp_result_o/rsp_fflags_o = fu_result_i/fu_fflags_i, passed through unregistered.
  - Pop when fu_valid_i && fu_ready_o && count>0.
- Orphan result: fu_valid_i with count==0 is drained (fu_ready_o=1), not routed, and sets err_orphan_o until reset.
- Full: count==ID_DEPTH blocks issue even when a pop occurs in the same cycle. This gives a registered-only full path.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo ID_DEPTH. count is clog2(ID_DEPTH)+1 bits wide.
- A requester holding valid with rsp_ready_i low stalls only through unit backpressure. Ordering is strictly in-order.
- Reset mid-operation: FIFO cleared. The unit must be reset in the same cycle; in-flight results are discarded by the system.

Optional Feature:
FPMV_ARB_PERF_EN:
- Defined: adds output perf_issue_o (32*NUM_REQ), per-requester 32-bit wrapping counters incremented on each issue of that requester.
- Also adds perf_stall_o (32), counting cycles with fu_valid_o=1 && fu_ready_i=0, plus cycles with any valid && count==ID_DEPTH.
- All counters reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package/define file:
  - FN_* op encodings, already shared.
  - NUM_REQ-derived ID width macro.
  - Perf counter width constant (32).
- One natural sub-module: fpmv_arb_id_fifo. It is a synchronous FIFO of requester IDs with push/pop/full/empty/count.
- Round-robin search stays inline.

Test Plan:
- Single requester 0, op FSGNJ, a=0x3F800000, b=0xBF800000, unit returns 0xBF800000 2 cycles later -> rsp_valid_o=0001, rsp_result_o=0xBF800000, FIFO count 1->0.
- All 4 valid continuously, fu_ready_i=1, rsp_ready all 1 -> grants 0,1,2,3,0,... one per cycle; responses return in the same order to the matching rsp_valid_o bit.
- Hold rsp_ready_i=0 for all, unit accepts 4 issues -> count=4, fu_valid_o=0, req_ready_o=0; release -> 4 pops in order, issue resumes when count<4.
- Requesters 1 and 3 valid, rr_ptr=2 -> grant 3 first, then 1; rr_ptr becomes 0 then 2.
- fu_valid_i=1 with FIFO empty -> fu_ready_o=1, no rsp_valid_o, err_orphan_o=1 and sticky until rst.
- Assert rst for 1 cycle with count=3 -> next cycle count=0, rr_ptr=0, all outputs 0 during reset. With FPMV_ARB_PERF_EN, perf counters read 0.
